// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Round-robin arbitration is enabled by defining WB_ARB_RR_EN.
package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int WB_NREQ  = 3;
    localparam int WB_IDX_W = 2;

    typedef enum logic [WB_IDX_W-1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_MDU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    // Successor of a requester index, wrapping at nreq.
    function automatic logic [WB_IDX_W-1:0] wb_ptr_next(input logic [WB_IDX_W-1:0] idx,
                                                        input int nreq);
        logic [WB_IDX_W-1:0] nxt;
        if (int'(idx) + 1 >= nreq) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Writeback-port arbiter: fixed priority (index 0 highest) by default,
// round-robin from ptr when WB_ARB_RR_EN is defined.
module wb_rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = WB_NREQ
) (
    input  logic [NREQ-1:0]     req,
    input  logic [WB_IDX_W-1:0] ptr,
    input  logic                hold,
    output logic [NREQ-1:0]     gnt,
    output logic [WB_IDX_W-1:0] gnt_idx,
    output logic [WB_IDX_W-1:0] ptr_nxt
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
`ifdef WB_ARB_RR_EN
        // Visit requesters in the order ptr, ptr+1, ... wrapping at NREQ.
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (j == (int'(ptr) + k) % NREQ)) begin
                    found   = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = WB_IDX_W'(j);
                end
            end
        end
`else
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = WB_IDX_W'(j);
            end
        end
`endif
        if (hold) begin
            gnt   = '0;
            found = 1'b0;
        end
    end

`ifdef WB_ARB_RR_EN
    assign ptr_nxt = found ? wb_ptr_next(gnt_idx, NREQ) : ptr;
`else
    assign ptr_nxt = ptr;
`endif

endmodule

// File: rtl/regfile_wport_arb.sv
// Shares the register-file write port (we3/wa3/wd3) between NREQ writeback
// sources with one registered write per cycle. Macro WB_ARB_RR_EN selects round-robin.
module regfile_wport_arb
    import regfile_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                wb_hold,
    output logic                we3,
    output logic [AW-1:0]       wa3,
    output logic [DW-1:0]       wd3,
    output logic [WB_IDX_W-1:0] grant_id
);

    logic [NREQ-1:0]     gnt;
    logic [WB_IDX_W-1:0] gnt_idx;
    logic [WB_IDX_W-1:0] ptr_q;
    logic [WB_IDX_W-1:0] ptr_nxt;

    logic                accept_p0;
    logic [AW-1:0]       addr_p0;
    logic [DW-1:0]       data_p0;

    logic                vld_p1;
    logic [AW-1:0]       addr_p1;
    logic [DW-1:0]       data_p1;
    logic [WB_IDX_W-1:0] gid_p1;

    wb_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .hold    (wb_hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr_nxt (ptr_nxt)
    );

    // ---- p0: arbitration, handshake and write selection ----
    assign req_ready = reset_n ? gnt : '0;
    assign accept_p0 = |req_ready;

    always_comb begin
        addr_p0 = '0;
        data_p0 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                addr_p0 = req_addr[i*AW +: AW];
                data_p0 = req_data[i*DW +: DW];
            end
        end
    end

`ifdef WB_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept_p0) begin
            ptr_q <= ptr_nxt;
        end
    end
`else
    logic [WB_IDX_W-1:0] unused_ptr_nxt;
    assign ptr_q          = '0;
    assign unused_ptr_nxt = ptr_nxt;
`endif

    // ---- p1: registered write, also the forwarding source ----
    // Writes to r0 complete the handshake but never raise we3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            gid_p1  <= '0;
        end else begin
            vld_p1 <= accept_p0 && (addr_p0 != '0);
            if (accept_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
                gid_p1  <= gnt_idx;
            end
        end
    end

    assign we3      = vld_p1;
    assign wa3      = addr_p1;
    assign wd3      = data_p1;
    assign grant_id = gid_p1;

endmodule
